ram_write_queue: RTL

- Posted-write buffer sitting directly upstream of ram_word's write port C.
- Accepts (address, data) write requests from the core over a valid/ready handshake and queues them in a DEPTH-entry FIFO.
- Drains one entry per clock into port_c_address/port_c_data/port_c_we, so the core never stalls on a single write; it stalls only when the queue is full.

---
 rtl/ram_write_queue.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ram_write_queue.sv
// ram_write_queue: posted-write buffer in front of ram_word write port C.
// Requests are accepted over a valid/ready handshake into a DEPTH-entry FIFO.
// The FIFO drains at most one entry per clock into registered port C outputs.
// Optional feature: define RAM_WQ_FWD_EN to add read-after-write forwarding.
// The forwarding lookup compares fwd_address against queued entries and port C.
module ram_write_queue #(
  parameter int AWIDTH = 8,
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [AWIDTH-1:0]            in_address,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         drain_en,
  input  logic                         flush,
  output logic [AWIDTH-1:0]            port_c_address,
  output logic [WIDTH-1:0]             port_c_data,
  output logic                         port_c_we,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
`ifdef RAM_WQ_FWD_EN
  ,
  input  logic [AWIDTH-1:0]            fwd_address,
  output logic                         fwd_hit,
  output logic [WIDTH-1:0]             fwd_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [WIDTH-1:0]  data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AWIDTH-1:0] pc_addr_q, pc_addr_d;
  logic [WIDTH-1:0]  pc_data_q, pc_data_d;
  logic              pc_we_q, pc_we_d;
  logic              push, pop;

  // Status flags are pure functions of the registered count, so in_ready never
  // depends combinationally on a same-cycle pop.
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_COUNT);
  assign in_ready = !full;
  assign count    = count_q;

  assign port_c_address = pc_addr_q;
  assign port_c_data    = pc_data_q;
  assign port_c_we      = pc_we_q;

  // Next-state: push/pop decisions, pointer and count updates, port C load.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push      = in_valid && in_ready && !flush;
    pop       = drain_en && !empty && !flush;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    pc_addr_d = pc_addr_q;
    pc_data_d = pc_data_q;
    pc_we_d   = 1'b0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so natural overflow gives modulo-DEPTH wrap.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + 1'b1;
        pc_addr_d = mem_q[rd_ptr_q].addr;
        pc_data_d = mem_q[rd_ptr_q].data;
        pc_we_d   = 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control and port C registers; reset drops port_c_we immediately.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      pc_addr_q <= '0;
      pc_data_q <= '0;
      pc_we_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      pc_addr_q <= pc_addr_d;
      pc_data_q <= pc_data_d;
      pc_we_q   <= pc_we_d;
    end
  end

  // Queue storage write on an accepted push.
  // NOTE: storage has no reset; count and pointers define which slots are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{addr: in_address, data: in_data};
    end
  end

`ifdef RAM_WQ_FWD_EN
  logic [PW-1:0] fwd_idx;

  // Forwarding lookup: port C is lowest priority, then queued entries from
  // oldest to newest, so the last match written is the youngest value.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (pc_we_q && (pc_addr_q == fwd_address)) begin
      fwd_hit  = 1'b1;
      fwd_data = pc_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (mem_q[fwd_idx].addr == fwd_address)) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_q[fwd_idx].data;
      end
    end
  end
`endif

endmodule
